// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit and the decoder that drives it.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MUL  = 2'd0,
    MDU_MULU = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DIVU = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_CALC   = 2'd2,
    ST_DONE   = 2'd3
  } mdu_state_t;

  // True for either divide flavour.
  function automatic logic op_is_div(mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // True for the two's-complement flavours.
  function automatic logic op_is_signed(mdu_op_t op);
    return (op == MDU_MUL) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/ex_mdu.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// one iteration per cycle over a shared 2*XLEN+1 working register.
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [1:0]          op_i,
  input  logic [XLEN-1:0]     opdata1_i,
  input  logic [XLEN-1:0]     opdata2_i,
  input  logic                annul_i,
  output logic [2*XLEN-1:0]   result_o,
  output logic                ready_o,
  output logic                div_by_zero_o,
  output logic                stallreq_o
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned AW    = 2 * XLEN + 1;

  mdu_state_t        state_q;
  logic [CNT_W-1:0]  cnt_q;
  mdu_op_t           op_q;
  logic              neg1_q;
  logic              neg2_q;
  logic              dz_q;
  logic [XLEN-1:0]   b_q;
  logic [AW-1:0]     acc_q;

  mdu_op_t           op_in;
  logic              signed_in;
  logic              div_in;
  logic              neg1_in;
  logic              neg2_in;
  logic [XLEN-1:0]   mag1_in;
  logic [XLEN-1:0]   mag2_in;
  logic              accept;
  logic              div_zero_in;
  logic [XLEN:0]     mul_sum;
  logic [AW-1:0]     mul_next;
  logic [AW-1:0]     div_shift;
  logic              div_ok;
  logic [XLEN:0]     div_trial;
  logic [AW-1:0]     div_next;
  logic [XLEN-1:0]   dividend_raw;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;
  logic [2*XLEN-1:0] final_res;

  // Operand conditioning, one datapath iteration, and final sign correction.
  always_comb begin
    op_in        = mdu_op_t'(op_i);
    signed_in    = op_is_signed(op_in);
    div_in       = op_is_div(op_in);
    neg1_in      = signed_in & opdata1_i[XLEN-1];
    neg2_in      = signed_in & opdata2_i[XLEN-1];
    mag1_in      = neg1_in ? -opdata1_i : opdata1_i;
    mag2_in      = neg2_in ? -opdata2_i : opdata2_i;
    accept       = (state_q == ST_IDLE) && start_i && !annul_i;
    div_zero_in  = div_in && (opdata2_i == '0);

    // Multiply: conditionally add multiplicand into the high half, shift right.
    mul_sum      = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next     = {1'b0, mul_sum, acc_q[XLEN-1:1]};

    // Divide: shift left, subtract divisor from partial remainder if it fits.
    div_shift    = {acc_q[AW-2:0], 1'b0};
    div_ok       = div_shift[AW-1:XLEN] >= {1'b0, b_q};
    div_trial    = div_shift[AW-1:XLEN] - {1'b0, b_q};
    div_next     = div_ok ? {div_trial, div_shift[XLEN-1:1], 1'b1} : div_shift;

    // Divide-by-zero reports the dividend exactly as the pipeline supplied it.
    dividend_raw = neg1_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    prod         = acc_q[2*XLEN-1:0];
    quot         = acc_q[XLEN-1:0];
    rem          = acc_q[2*XLEN-1:XLEN];
    if ((op_q == MDU_DIV) && (neg1_q ^ neg2_q)) quot = -quot;
    if ((op_q == MDU_DIV) && neg1_q)            rem  = -rem;
    if ((op_q == MDU_MUL) && (neg1_q ^ neg2_q)) prod = -prod;

    if (dz_q)                  final_res = acc_q[2*XLEN-1:0];
    else if (op_is_div(op_q))  final_res = {rem, quot};
    else                       final_res = prod;

    stallreq_o   = !rst && (accept || (state_q == ST_BYZERO) || (state_q == ST_CALC));
  end

  // Control FSM: sequencing, iteration counter and registered result/handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      result_o      <= '0;
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q   <= '0;
            state_q <= div_zero_in ? ST_BYZERO : ST_CALC;
          end
        end
        ST_BYZERO: begin
          state_q <= annul_i ? ST_IDLE : ST_DONE;
        end
        ST_CALC: begin
          if (annul_i) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (!annul_i) begin
            result_o      <= final_res;
            ready_o       <= 1'b1;
            div_by_zero_o <= dz_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Datapath: operand capture on accept, then one iteration per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= MDU_MUL;
      neg1_q <= 1'b0;
      neg2_q <= 1'b0;
      dz_q   <= 1'b0;
      b_q    <= '0;
      acc_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= op_in;
            neg1_q <= neg1_in;
            neg2_q <= neg2_in;
            dz_q   <= div_zero_in;
            b_q    <= div_in ? mag2_in : mag1_in;
            acc_q  <= {(XLEN + 1)'(0), div_in ? mag1_in : mag2_in};
          end
        end
        ST_CALC: begin
          if (!annul_i) acc_q <= op_is_div(op_q) ? div_next : mul_next;
        end
        ST_BYZERO: begin
          acc_q <= {1'b0, dividend_raw, {XLEN{1'b1}}};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_ex_mdu;
  import mdu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [1:0]        op_i = 2'd0;
  logic [XLEN-1:0]   opdata1_i = '0;
  logic [XLEN-1:0]   opdata2_i = '0;
  logic              annul_i = 1'b0;
  logic [2*XLEN-1:0] result_o;
  logic              ready_o;
  logic              div_by_zero_o;
  logic              stallreq_o;

  int n_checks = 0;
  int n_pass   = 0;

  ex_mdu #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .op_i          (op_i),
    .opdata1_i     (opdata1_i),
    .opdata2_i     (opdata2_i),
    .annul_i       (annul_i),
    .result_o      (result_o),
    .ready_o       (ready_o),
    .div_by_zero_o (div_by_zero_o),
    .stallreq_o    (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model from the arithmetic definition of each operation.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b, output logic dz);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    dz = 1'b0;
    case (op)
      2'd0: return sa * sb;
      2'd1: return ua * ub;
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1;
          return {a, 32'hFFFF_FFFF};
        end
        if (op == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = $signed(ua / ub);
          r = $signed(ua % ub);
        end
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // One full operation with latency, stall and pulse-width checks.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit start_now, input bit keep_next, input bit noise);
    logic [63:0] exp;
    logic        exp_dz;
    int          lat;
    int          stall_low;
    exp = ref_result(op, a, b, exp_dz);
    if (!start_now) @(negedge clk);
    start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
    #1 check("stall_on_start", 64'(stallreq_o), 64'd1);
    @(posedge clk); #1;
    start_i = 1'b0;
    opdata1_i = $urandom; opdata2_i = $urandom;
    lat = 0; stall_low = 0;
    while (!ready_o && lat < 100) begin
      if (!stallreq_o) stall_low++;
      if (noise && lat == 5) begin start_i = 1'b1; op_i = 2'($urandom); end
      if (noise && lat == 6) start_i = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("ready_seen", 64'(ready_o), 64'd1);
    check("latency", 64'(lat), exp_dz ? 64'd2 : 64'd33);
    check("result", result_o, exp);
    check("div_by_zero", 64'(div_by_zero_o), 64'(exp_dz));
    check("stall_low_cycles", 64'(stall_low), 64'd1);
    if (!keep_next) begin
      @(posedge clk); #1;
      check("ready_pulse_width", 64'(ready_o), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] prev;
    bit          saw;
    logic [1:0]  op;
    logic [31:0] a, b;

    #12;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op(MDU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(MDU_MUL,  32'hFFFF_FFFD, 32'h0000_0007, 0, 0, 0);
    run_op(MDU_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0);
    run_op(MDU_DIVU, 32'd100,       32'd7,         0, 0, 0);
    run_op(MDU_DIVU, 32'd100,       32'd0,         0, 0, 0);
    run_op(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    // Back-to-back: next start in the ready cycle.
    run_op(MDU_MUL,  32'h8000_0000, 32'h8000_0000, 0, 1, 0);
    run_op(MDU_DIV,  32'h7FFF_FFFF, 32'hFFFF_FFFE, 1, 0, 1);

    // Annul mid-CALC.
    prev = result_o;
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_MULU; opdata1_i = 32'h1234_5678; opdata2_i = 32'h9ABC_DEF0;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(posedge clk); #1 annul_i = 1'b0;
    check("annul_stall_low", 64'(stallreq_o), 64'd0);
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) saw = 1'b1;
      if (i < 39) begin @(posedge clk); #1; end
    end
    check("annul_no_ready", 64'(saw), 64'd0);
    check("annul_result_held", result_o, prev);
    run_op(MDU_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 1, 0, 0);

    // Start together with annul in IDLE is refused.
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; op_i = MDU_MUL; opdata1_i = 32'd5; opdata2_i = 32'd6;
    #1 check("idle_annul_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1 start_i = 1'b0; annul_i = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o || stallreq_o) saw = 1'b1;
      @(posedge clk); #1;
    end
    check("idle_annul_ignored", 64'(saw), 64'd0);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start_i = 1'b1; op_i = MDU_MULU; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'hFFFF_FFFF;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("rst_result", result_o, 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(MDU_MUL, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 0, 0);

    // Randomized operations with corner-biased operands.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'hFFFF_FFFF;
        1: b = 32'd0;
        2: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (op == MDU_DIV && b == 32'd0) b = 32'd3;
      run_op(op, a, b, 0, 0, n[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
